axis_tx_arbiter: RTL and testbench
==================================

# axis_tx_arbiter

Packet-aware round-robin arbiter that shares one NoC AXI-Stream transmit port among NREQ dispatcher-style sources. A grant is held from a packet's first accepted beat through its tlast beat, so packets are never interleaved. The winning beat passes through a one-entry registered output stage. The block sits between the per-source dispatchers and the NoC router's tx interface.

## Interface
- NREQ, 4: number of requesters; must be at least 2.
- DATAW, 587: tdata width (payload plus embedded user field).
- DESTW, 7: tdest width.
- IDW, 32: tid width.
- GW, $clog2(NREQ): grant index width.

- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_tvalid  in  NREQ  per-requester valid.
- in_tdata  in  NREQ*DATAW  requester r occupies bits [r*DATAW +: DATAW].
- in_tdest  in  NREQ*DESTW  per-requester destination.
- in_tid  in  NREQ*IDW  per-requester id.
- in_tlast  in  NREQ  per-requester end of packet.
- in_tready  out  NREQ  per-requester ready; at most one bit is high in any cycle.
- out_tvalid  out  1  output valid.
- out_tdata  out  DATAW  output data.
- out_tdest  out  DESTW  output destination.
- out_tid  out  IDW  output id.
- out_tlast  out  1  output end of packet.
- out_tready  in  1  downstream ready.
- grant_id  out  GW  index of the current or most recent grantee.
- busy  out  1  high while in LOCKED (mid-packet).

## Operation
- State: FSM {IDLE, LOCKED}, round-robin pointer ptr[GW-1:0], grant register gnt[GW-1:0], and an output slot (register plus out_tvalid).
- slot_free = ~out_tvalid | out_tready.
- Selection in IDLE: sel is the first r with in_tvalid[r], searching ptr, ptr+1, … modulo NREQ. The search is combinational.
- Selection in LOCKED: sel = gnt.
- Ready:
  - in_tready[sel] = slot_free & state_ok.
  - state_ok is (IDLE and any in_tvalid) or LOCKED.
  - All other in_tready bits are 0.
- Accept: accept = in_tvalid[sel] & in_tready[sel]. On accept, the slot loads {tdata, tdest, tid, tlast} of sel and out_tvalid goes to 1.
- Slot drain: if out_tready is high and there is no accept, out_tvalid goes to 0. Slot contents hold while out_tvalid=1 and out_tready=0.
- Transitions:
  - IDLE, accept with tlast=0: go to LOCKED, gnt <= sel.
  - IDLE, accept with tlast=1 (single-beat packet): stay in IDLE, gnt <= sel, ptr <= sel+1 mod NREQ.
  - LOCKED, accept with tlast=1: go to IDLE, ptr <= gnt+1 mod NREQ.
  - LOCKED with in_tvalid[gnt]=0: hold LOCKED. Other requesters stay stalled with no timeout.
- Pointer wrap: ptr+1 wraps to 0 at NREQ-1. For non-power-of-2 NREQ the modulo is explicit.
- grant_id = gnt. busy = (state==LOCKED).

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, ptr=0, gnt=0.
  - out_tvalid=0; out_tdata, out_tdest, out_tid, out_tlast = 0.
  - in_tready=0, busy=0, grant_id=0.
- Latency: a beat accepted at edge N appears on out_* after edge N and holds until the first edge with out_tready=1.
- Throughput: 1 beat/cycle while out_tready is held high.
- Packet boundaries: there is no bubble between packets. A tlast accept at edge N lets IDLE arbitration accept the next packet's first beat at edge N+1.
- Arbitration and the first-beat accept happen in the same cycle. in_tready depends combinationally on in_tvalid, ptr and out_tready.
- Source rules:
  - A source must not deassert tvalid or change payload while tvalid=1 and tready=0.
  - Losing sources see tready=0 and must hold.
- Simultaneous events: an accept together with out_tready=1 in the same cycle replaces the slot with no bubble.
- Mid-packet reset: a reset during LOCKED discards the slot and the lock. The partial packet is lost; upstream must also be reset.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs go to 0 immediately (asynchronously), with no clk edge needed.
- Round-robin fairness, NREQ=4, out_tready=1:
  - Stimulus: all four sources valid, each sending 2-beat packets.
  - Required output order: 0,0,1,1,2,2,3,3,0,0.
  - in_tready is one-hot, and busy toggles 1,0 per packet.
- Packet locking:
  - Stimulus: source 1 sends a 4-beat packet with a 2-cycle in_tvalid gap after beat 2; source 2 is valid throughout.
  - Required: no source-2 beat appears until after source 1's tlast, and busy stays 1 across the gap.
- Backpressure:
  - Stimulus: out_tready=0 for 5 cycles while the slot holds source 3's beat D=0x1A5.
  - Required: out_tdata stays 0x1A5, and all in_tready are 0 for those cycles.
  - Required: after out_tready=1, the next beat appears the following cycle.
- Single-beat packets and wrap:
  - Stimulus: ptr=3 with sources 3 and 0 valid, each sending 1-beat tlast packets.
  - Required: output order 3,0 on consecutive cycles, ptr ends at 1, and busy stays 0 throughout.
- Skip idle requesters:
  - Stimulus: only source 2 is valid, with ptr=0.
  - Required: source 2 is granted in the same cycle, grant_id=2, and after its tlast ptr=3.

Source files
------------

// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter
//   Packet-aware round-robin arbiter sharing one AXI-Stream transmit port among
//   NREQ sources. A grant is held from a packet's first accepted beat through its
//   tlast beat, so packets never interleave. The winning beat is captured in a
//   one-entry registered output slot.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_tvalid/in_tlast   per-requester valid / end of packet        [NREQ]
//   in_tdata             requester r at [r*DATAW +: DATAW]
//   in_tdest, in_tid     per-requester destination / id, packed the same way
//   in_tready            per-requester ready, at most one bit high
//   out_t*               registered output stream, out_tready from downstream
//   grant_id             current or most recent grantee
//   busy                 high while a packet is mid-flight (grant locked)
module axis_tx_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DATAW = 587,
    parameter int unsigned DESTW = 7,
    parameter int unsigned IDW   = 32,
    parameter int unsigned GW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       in_tvalid,
    input  logic [NREQ*DATAW-1:0] in_tdata,
    input  logic [NREQ*DESTW-1:0] in_tdest,
    input  logic [NREQ*IDW-1:0]   in_tid,
    input  logic [NREQ-1:0]       in_tlast,
    output logic [NREQ-1:0]       in_tready,
    output logic                  out_tvalid,
    output logic [DATAW-1:0]      out_tdata,
    output logic [DESTW-1:0]      out_tdest,
    output logic [IDW-1:0]        out_tid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e           state_q;
    logic [GW-1:0]    ptr_q;
    logic [GW-1:0]    gnt_q;
    logic             slot_vld_q;
    logic [DATAW-1:0] slot_data_q;
    logic [DESTW-1:0] slot_dest_q;
    logic [IDW-1:0]   slot_id_q;
    logic             slot_last_q;

    // Per-requester views of the packed payload buses
    logic [DATAW-1:0] tdata_arr [NREQ];
    logic [DESTW-1:0] tdest_arr [NREQ];
    logic [IDW-1:0]   tid_arr   [NREQ];

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign tdata_arr[r] = in_tdata[r*DATAW +: DATAW];
        assign tdest_arr[r] = in_tdest[r*DESTW +: DESTW];
        assign tid_arr[r]   = in_tid[r*IDW +: IDW];
    end

    logic [GW-1:0] sel_idle;
    logic [GW-1:0] cand;
    logic          any_valid;
    logic [GW-1:0] sel;
    logic [GW-1:0] ptr_next;
    logic          slot_free;
    logic          grant_ok;
    logic          accept;
    logic          sel_last;

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        sel_idle  = ptr_q;
        cand      = '0;
        any_valid = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = GW'((int'(ptr_q) + i) % int'(NREQ));
            if (!any_valid && in_tvalid[cand]) begin
                sel_idle  = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign sel       = (state_q == StLocked) ? gnt_q : sel_idle;
    assign slot_free = ~slot_vld_q | out_tready;
    // rst_n gating keeps in_tready low while reset is asserted.
    assign grant_ok  = rst_n & slot_free & ((state_q == StLocked) | any_valid);
    assign accept    = in_tvalid[sel] & grant_ok;
    assign sel_last  = in_tlast[sel];
    // Explicit wrap so non-power-of-2 NREQ stays in range.
    assign ptr_next  = (sel == GW'(NREQ - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        in_tready      = '0;
        in_tready[sel] = grant_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gnt_q       <= '0;
            slot_vld_q  <= 1'b0;
            slot_data_q <= '0;
            slot_dest_q <= '0;
            slot_id_q   <= '0;
            slot_last_q <= 1'b0;
        end else begin
            // An accept overwrites the slot even when it drains this cycle.
            if (accept) begin
                slot_vld_q  <= 1'b1;
                slot_data_q <= tdata_arr[sel];
                slot_dest_q <= tdest_arr[sel];
                slot_id_q   <= tid_arr[sel];
                slot_last_q <= sel_last;
            end else if (out_tready) begin
                slot_vld_q  <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        gnt_q <= sel;
                        if (sel_last) begin
                            ptr_q <= ptr_next;
                        end else begin
                            state_q <= StLocked;
                        end
                    end
                end
                StLocked: begin
                    // Hold the lock through source gaps; no timeout.
                    if (accept && sel_last) begin
                        state_q <= StIdle;
                        ptr_q   <= ptr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_tvalid = slot_vld_q;
    assign out_tdata  = slot_data_q;
    assign out_tdest  = slot_dest_q;
    assign out_tid    = slot_id_q;
    assign out_tlast  = slot_last_q;
    assign grant_id   = gnt_q;
    assign busy       = (state_q == StLocked);

endmodule

// File: tb/tb_axis_tx_arbiter.sv
module tb_axis_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DATAW = 587;
    localparam int DESTW = 7;
    localparam int IDW   = 32;
    localparam int GW    = 2;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [DESTW-1:0] dest;
        logic [IDW-1:0]   id;
        logic             last;
        int               gap;   // idle cycles before this beat is presented
    } beat_t;

    logic                             clk = 1'b0;
    logic                             rst_n = 1'b0;
    logic [NREQ-1:0]                  in_tvalid = '0;
    logic [NREQ-1:0][DATAW-1:0]       in_tdata = '0;
    logic [NREQ-1:0][DESTW-1:0]       in_tdest = '0;
    logic [NREQ-1:0][IDW-1:0]         in_tid = '0;
    logic [NREQ-1:0]                  in_tlast = '0;
    logic [NREQ-1:0]                  in_tready;
    logic                             out_tvalid;
    logic [DATAW-1:0]                 out_tdata;
    logic [DESTW-1:0]                 out_tdest;
    logic [IDW-1:0]                   out_tid;
    logic                             out_tlast;
    logic                             out_tready = 1'b1;
    logic [GW-1:0]                    grant_id;
    logic                             busy;

    axis_tx_arbiter #(
        .NREQ (NREQ),
        .DATAW(DATAW),
        .DESTW(DESTW),
        .IDW  (IDW),
        .GW   (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tvalid (in_tvalid),
        .in_tdata  (in_tdata),
        .in_tdest  (in_tdest),
        .in_tid    (in_tid),
        .in_tlast  (in_tlast),
        .in_tready (in_tready),
        .out_tvalid(out_tvalid),
        .out_tdata (out_tdata),
        .out_tdest (out_tdest),
        .out_tid   (out_tid),
        .out_tlast (out_tlast),
        .out_tready(out_tready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [DATAW-1:0] got,
                            input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source side: packet queues and per-source presentation delay
    beat_t srcq [NREQ][$];
    int    hold [NREQ];
    int    seqn = 0;
    int    bp_cnt = 0;       // cycles of forced out_tready=0
    bit    rnd_tready = 0;
    int    cyc = 0;

    // Reference model: arbitration expressed as owner/pointer integers
    int    m_owner;          // -1 when no packet is in flight
    int    m_ptr;
    int    m_gnt;
    bit    m_slot_v;
    beat_t m_slot;
    int    m_src;
    int    out_log[$];       // source of each beat leaving the output port
    int    out_cyc[$];       // cycle at which it left

    function automatic beat_t mk_beat(int src, bit last, int gap);
        beat_t b;
        logic [607:0] w;
        for (int k = 0; k < 19; k++) w[k*32 +: 32] = $urandom;
        b.data = w[DATAW-1:0];
        b.data[15:0] = 16'(seqn);
        b.dest = DESTW'($urandom);
        b.id   = {8'(src), 24'(seqn)};
        b.last = last;
        b.gap  = gap;
        seqn++;
        return b;
    endfunction

    task automatic add_pkt(input int src, input int len, input int gap0,
                           input int gap_at, input int gap_n);
        for (int i = 0; i < len; i++) begin
            int g;
            g = (i == 0) ? gap0 : ((i == gap_at) ? gap_n : 0);
            if (srcq[src].size() == 0) hold[src] = g;
            srcq[src].push_back(mk_beat(src, i == len - 1, g));
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NREQ; r++) n += srcq[r].size();
        return n;
    endfunction

    function automatic int log_at(int i);
        return (i < out_log.size()) ? out_log[i] : -1;
    endfunction

    function automatic int cyc_at(int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -100;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, out_tvalid, 0);
        check_eq({tag, "_tdata"}, out_tdata, 0);
        check_eq({tag, "_tdest"}, out_tdest, 0);
        check_eq({tag, "_tid"}, out_tid, 0);
        check_eq({tag, "_tlast"}, out_tlast, 0);
        check_eq({tag, "_tready"}, in_tready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_grant"}, grant_id, 0);
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        in_tvalid = '0;
        for (int r = 0; r < NREQ; r++) begin
            srcq[r].delete();
            hold[r] = 0;
        end
        m_owner = -1; m_ptr = 0; m_gnt = 0; m_slot_v = 0; m_src = 0;
        out_log.delete(); out_cyc.delete();
        bp_cnt = 0; rnd_tready = 0; cyc = 0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] vld;
        logic [NREQ-1:0] exp_rdy;
        int  sel;
        bit  any;
        bit  acc;
        bit  slot_free;

        if (bp_cnt > 0) begin
            out_tready = 1'b0;
            bp_cnt--;
        end else begin
            out_tready = rnd_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        for (int r = 0; r < NREQ; r++) begin
            vld[r] = (srcq[r].size() > 0) && (hold[r] == 0);
            in_tvalid[r] = vld[r];
            if (vld[r]) begin
                in_tdata[r] = srcq[r][0].data;
                in_tdest[r] = srcq[r][0].dest;
                in_tid[r]   = srcq[r][0].id;
                in_tlast[r] = srcq[r][0].last;
            end else begin
                in_tdata[r] = '0;
                in_tdest[r] = '0;
                in_tid[r]   = '0;
                in_tlast[r] = 1'b0;
            end
        end
        #2;

        any = 0;
        sel = 0;
        if (m_owner >= 0) begin
            sel = m_owner;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (vld[(m_ptr + k) % NREQ]) begin
                    sel = (m_ptr + k) % NREQ;
                    any = 1;
                end
            end
        end
        slot_free = !m_slot_v || out_tready;
        exp_rdy = '0;
        if (slot_free && (m_owner >= 0 || any)) exp_rdy[sel] = 1'b1;

        check_eq("in_tready", in_tready, exp_rdy);
        check_eq("rdy_onehot0", $countones(in_tready) <= 1, 1);
        if (out_tvalid && !out_tready) check_eq("bp_no_rdy", in_tready, 0);
        check_eq("out_tvalid", out_tvalid, m_slot_v);
        check_eq("busy", busy, m_owner >= 0);
        check_eq("grant_id", grant_id, m_gnt);
        if (m_slot_v) begin
            check_eq("out_tdata", out_tdata, m_slot.data);
            check_eq("out_tdest", out_tdest, m_slot.dest);
            check_eq("out_tid", out_tid, m_slot.id);
            check_eq("out_tlast", out_tlast, m_slot.last);
            if (out_tready) begin
                out_log.push_back(m_src);
                out_cyc.push_back(cyc);
            end
        end

        acc = exp_rdy[sel] && vld[sel];
        if (acc) begin
            m_slot   = srcq[sel][0];
            m_src    = sel;
            m_slot_v = 1;
            m_gnt    = sel;
            if (srcq[sel][0].last) begin
                m_owner = -1;
                m_ptr   = (sel + 1) % NREQ;
            end else begin
                m_owner = sel;
            end
        end else if (out_tready) begin
            m_slot_v = 0;
        end

        @(posedge clk);
        for (int r = 0; r < NREQ; r++) begin
            if (acc && r == sel) begin
                void'(srcq[r].pop_front());
                hold[r] = (srcq[r].size() > 0) ? srcq[r][0].gap : 0;
            end else if (hold[r] > 0 && srcq[r].size() > 0) begin
                hold[r]--;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int total;
        int rr_exp[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        @(negedge clk);
        do_reset();

        // Round robin with 2-beat packets from all four sources
        for (int r = 0; r < NREQ; r++) begin
            add_pkt(r, 2, 0, 0, 0);
            add_pkt(r, 2, 0, 0, 0);
        end
        run(14);
        for (int i = 0; i < 10; i++) check_eq("rr_order", log_at(i), rr_exp[i]);

        // Packet locking across a source gap
        do_reset();
        add_pkt(1, 4, 0, 2, 2);
        add_pkt(2, 2, 0, 0, 0);
        run(12);
        for (int i = 0; i < 4; i++) check_eq("lock_src1", log_at(i), 1);
        check_eq("lock_src2a", log_at(4), 2);
        check_eq("lock_src2b", log_at(5), 2);

        // Backpressure: source 3 beat 0x1A5 held for 5 cycles, then source 0
        do_reset();
        add_pkt(3, 1, 0, 0, 0);
        srcq[3][0].data = DATAW'(12'h1A5);
        add_pkt(0, 1, 1, 0, 0);
        bp_cnt = 6;
        run(10);
        check_eq("bp_first", log_at(0), 3);
        check_eq("bp_release_cyc", cyc_at(0), 6);
        check_eq("bp_next", log_at(1), 0);
        check_eq("bp_next_cyc", cyc_at(1) - cyc_at(0), 1);

        // Single-beat packets and pointer wrap: ptr 3 -> 3,0 -> ptr 1
        do_reset();
        add_pkt(2, 1, 0, 0, 0);
        add_pkt(3, 1, 1, 0, 0);
        add_pkt(0, 1, 1, 0, 0);
        add_pkt(2, 1, 2, 0, 0);
        add_pkt(1, 1, 3, 0, 0);
        run(8);
        check_eq("wrap_3", log_at(1), 3);
        check_eq("wrap_0", log_at(2), 0);
        check_eq("wrap_consec", cyc_at(2) - cyc_at(1), 1);
        check_eq("wrap_ptr1", log_at(3), 1);
        check_eq("wrap_then2", log_at(4), 2);

        // Skip idle requesters; afterwards ptr must sit at 3
        do_reset();
        add_pkt(2, 2, 0, 0, 0);
        add_pkt(0, 1, 3, 0, 0);
        add_pkt(3, 1, 3, 0, 0);
        cycle();
        check_eq("skip_grant", grant_id, 2);
        run(7);
        check_eq("skip_a", log_at(0), 2);
        check_eq("skip_b", log_at(1), 2);
        check_eq("skip_ptr3", log_at(2), 3);
        check_eq("skip_then0", log_at(3), 0);

        // Asynchronous reset in the middle of a locked packet
        do_reset();
        add_pkt(1, 4, 0, 0, 0);
        run(2);
        check_eq("pre_rst_busy", busy, 1);
        check_eq("pre_rst_grant", grant_id, 1);
        in_tvalid = '1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        do_reset();

        // Randomized packets, gaps and backpressure
        total = 0;
        for (int p = 0; p < 6; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                int len;
                len = $urandom_range(1, 4);
                total += len;
                add_pkt(r, len, $urandom_range(0, 2), $urandom_range(1, 3),
                        $urandom_range(0, 2));
            end
        end
        rnd_tready = 1;
        for (int n = 0; n < 3000 && (pending() > 0 || m_slot_v); n++) cycle();
        check_eq("rand_drained", pending() + int'(m_slot_v), 0);
        check_eq("rand_count", out_log.size(), total);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
